cnn_layer_sched: RTL and testbench

CNN_LAYER_SCHED -- requirements
Module: cnn_layer_sched

---
 rtl/cnn_layer_sched.sv | 187 ++++++++++++++++++
 tb/tb_cnn_layer_sched.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cnn_layer_sched.sv
// Layer scheduler for a CNN accelerator: walks a descriptor ROM one layer at
// a time, validates each descriptor, hands the configuration to the conv and
// pool engines, sequences their start/finish handshakes and flips the
// ping-pong feature-map buffer between layers.
module cnn_layer_sched #(
  parameter int MAXL = 8
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       cnn_start_i,
  input  logic [3:0] num_layers_i,
  output logic [3:0] desc_idx_o,
  input  logic [7:0] desc_di_i,
  input  logic [7:0] desc_do_i,
  input  logic [7:0] desc_dr_i,
  input  logic [7:0] desc_dc_i,
  input  logic [3:0] desc_dkr_i,
  input  logic [3:0] desc_dkc_i,
  input  logic       desc_relu_i,
  input  logic       desc_mp_i,
  output logic [7:0] di_o,
  output logic [7:0] do_o,
  output logic [7:0] dr_o,
  output logic [7:0] dc_o,
  output logic [3:0] dkr_o,
  output logic [3:0] dkc_o,
  output logic       relu_o,
  output logic       maxpooling_or_not_o,
  output logic [7:0] dr_out_o,
  output logic [7:0] dc_out_o,
  output logic       start_o,
  input  logic       picture_finish_i,
  output logic       mp_enable_o,
  input  logic       mp_picture_finish_i,
  output logic       buf_sel_o,
  output logic [3:0] layer_idx_o,
  output logic [7:0] cnn_state_o,
  output logic       cnn_finish_o,
  output logic       cnn_err_o
);

  typedef enum logic [3:0] {
    IDLE       = 4'd0,
    FETCH      = 4'd1,
    LOAD       = 4'd2,
    CONV_START = 4'd3,
    CONV_WAIT  = 4'd4,
    MP_START   = 4'd5,
    MP_WAIT    = 4'd6,
    NEXT       = 4'd7,
    DONE       = 4'd8,
    ERR        = 4'd9
  } state_t;

  typedef struct packed {
    logic [7:0] di;
    logic [7:0] dout;
    logic [7:0] dr;
    logic [7:0] dc;
    logic [3:0] dkr;
    logic [3:0] dkc;
    logic       relu;
    logic       mp;
    logic [7:0] rout;
    logic [7:0] cout;
  } cfg_t;

  localparam logic [4:0] MaxLayers = 5'(MAXL);

  state_t     state_q, state_d;
  logic [3:0] layer_idx_q, layer_idx_d;
  logic [3:0] num_q, num_d;
  logic       buf_sel_q, buf_sel_d;
  logic       err_q, err_d;
  cfg_t       cfg_q, cfg_d;

  logic [7:0] rout, cout, exp_r, exp_c;
  logic [3:0] idx_inc;
  logic       bad;

  // State, layer bookkeeping and the registered layer configuration.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      layer_idx_q <= 4'd0;
      num_q       <= 4'd0;
      buf_sel_q   <= 1'b0;
      err_q       <= 1'b0;
      cfg_q       <= '0;
    end else begin
      state_q     <= state_d;
      layer_idx_q <= layer_idx_d;
      num_q       <= num_d;
      buf_sel_q   <= buf_sel_d;
      err_q       <= err_d;
      cfg_q       <= cfg_d;
    end
  end

  // Next-state logic, descriptor validation and chaining against the
  // previous layer (whose configuration is still held in cfg_q during LOAD).
  always_comb begin
    state_d     = state_q;
    layer_idx_d = layer_idx_q;
    num_d       = num_q;
    buf_sel_d   = buf_sel_q;
    err_d       = err_q;
    cfg_d       = cfg_q;
    rout        = desc_dr_i - {4'd0, desc_dkr_i} + 8'd1;
    cout        = desc_dc_i - {4'd0, desc_dkc_i} + 8'd1;
    exp_r       = cfg_q.mp ? {1'b0, cfg_q.rout[7:1]} : cfg_q.rout;
    exp_c       = cfg_q.mp ? {1'b0, cfg_q.cout[7:1]} : cfg_q.cout;
    idx_inc     = layer_idx_q + 4'd1;
    bad         = 1'b0;
    case (state_q)
      IDLE, ERR: begin
        if (cnn_start_i) begin
          err_d       = 1'b0;
          layer_idx_d = 4'd0;
          buf_sel_d   = 1'b0;
          num_d       = num_layers_i;
          state_d     = (num_layers_i == 4'd0) ? DONE : FETCH;
        end
      end
      FETCH:      state_d = LOAD;
      LOAD: begin
        cfg_d = '{di: desc_di_i, dout: desc_do_i, dr: desc_dr_i, dc: desc_dc_i,
                  dkr: desc_dkr_i, dkc: desc_dkc_i, relu: desc_relu_i,
                  mp: desc_mp_i, rout: rout, cout: cout};
        bad = (desc_dkr_i == 4'd0) || (desc_dkc_i == 4'd0) ||
              ({4'd0, desc_dkr_i} > desc_dr_i) || ({4'd0, desc_dkc_i} > desc_dc_i) ||
              (desc_mp_i && (rout[0] || cout[0])) ||
              ({1'b0, num_q} > MaxLayers);
        if (layer_idx_q != 4'd0) begin
          bad = bad || (desc_di_i != cfg_q.dout) ||
                (desc_dr_i != exp_r) || (desc_dc_i != exp_c);
        end
        if (bad) begin
          err_d   = 1'b1;
          state_d = ERR;
        end else begin
          state_d = CONV_START;
        end
      end
      CONV_START: state_d = CONV_WAIT;
      CONV_WAIT: begin
        if (picture_finish_i) state_d = cfg_q.mp ? MP_START : NEXT;
      end
      MP_START:   state_d = MP_WAIT;
      MP_WAIT: begin
        if (mp_picture_finish_i) state_d = NEXT;
      end
      NEXT: begin
        buf_sel_d = ~buf_sel_q;
        if (idx_inc == num_q) begin
          state_d = DONE;
        end else begin
          layer_idx_d = idx_inc;
          state_d     = FETCH;
        end
      end
      DONE:       state_d = IDLE;
      default:    state_d = IDLE;
    endcase
  end

  // Pulses are decoded from the state so reset removes them immediately.
  assign start_o             = (state_q == CONV_START);
  assign mp_enable_o         = (state_q == MP_START);
  assign cnn_finish_o        = (state_q == DONE);
  assign cnn_err_o           = err_q;
  assign cnn_state_o         = {4'd0, state_q};
  assign desc_idx_o          = layer_idx_q;
  assign layer_idx_o         = layer_idx_q;
  assign buf_sel_o           = buf_sel_q;
  assign di_o                = cfg_q.di;
  assign do_o                = cfg_q.dout;
  assign dr_o                = cfg_q.dr;
  assign dc_o                = cfg_q.dc;
  assign dkr_o               = cfg_q.dkr;
  assign dkc_o               = cfg_q.dkc;
  assign relu_o              = cfg_q.relu;
  assign maxpooling_or_not_o = cfg_q.mp;
  assign dr_out_o            = cfg_q.rout;
  assign dc_out_o            = cfg_q.cout;

endmodule

// File: tb/tb_cnn_layer_sched.sv
// Directed bench for the CNN layer scheduler with a one-cycle-latency
// descriptor ROM model.
module tb_cnn_layer_sched;

  typedef struct packed {
    logic [7:0] di;
    logic [7:0] dout;
    logic [7:0] dr;
    logic [7:0] dc;
    logic [3:0] dkr;
    logic [3:0] dkc;
    logic       relu;
    logic       mp;
  } desc_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cnn_start = 1'b0;
  logic [3:0] num_layers = 4'd0;
  logic       picture_finish = 1'b0;
  logic       mp_picture_finish = 1'b0;
  logic [3:0] desc_idx;
  logic [7:0] di, dout, dr, dc, dr_out, dc_out, cnn_state;
  logic [3:0] dkr, dkc, layer_idx;
  logic       relu, mpn, start, mp_enable, buf_sel, cnn_finish, cnn_err;

  desc_t rom [16];
  desc_t rq = '0;

  int n_tests = 0;
  int n_fail  = 0;
  int n_start = 0;
  int n_mp    = 0;
  int n_fin   = 0;

  logic [3:0] s1, i1;
  logic       e1;

  always #5 clk = ~clk;

  always @(posedge clk) rq <= rom[desc_idx];

  cnn_layer_sched #(.MAXL(8)) dut (
    .clk_i(clk), .rst_ni(rst_n), .cnn_start_i(cnn_start), .num_layers_i(num_layers),
    .desc_idx_o(desc_idx),
    .desc_di_i(rq.di), .desc_do_i(rq.dout), .desc_dr_i(rq.dr), .desc_dc_i(rq.dc),
    .desc_dkr_i(rq.dkr), .desc_dkc_i(rq.dkc), .desc_relu_i(rq.relu), .desc_mp_i(rq.mp),
    .di_o(di), .do_o(dout), .dr_o(dr), .dc_o(dc), .dkr_o(dkr), .dkc_o(dkc),
    .relu_o(relu), .maxpooling_or_not_o(mpn), .dr_out_o(dr_out), .dc_out_o(dc_out),
    .start_o(start), .picture_finish_i(picture_finish),
    .mp_enable_o(mp_enable), .mp_picture_finish_i(mp_picture_finish),
    .buf_sel_o(buf_sel), .layer_idx_o(layer_idx), .cnn_state_o(cnn_state),
    .cnn_finish_o(cnn_finish), .cnn_err_o(cnn_err)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Advance one clock and sample just after the edge, tallying pulses.
  task automatic step();
    @(posedge clk);
    #1;
    if (start)      n_start++;
    if (mp_enable)  n_mp++;
    if (cnn_finish) n_fin++;
  endtask

  task automatic clr();
    n_start = 0;
    n_mp    = 0;
    n_fin   = 0;
  endtask

  // Launch a run and act as both engines until DONE or ERR is reached.
  task automatic run(input logic [3:0] n, output logic [3:0] st1,
                     output logic er1, output logic [3:0] ix1);
    logic ended;
    ended      = 1'b0;
    cnn_start  = 1'b1;
    num_layers = n;
    step();
    cnn_start = 1'b0;
    st1 = cnn_state[3:0];
    er1 = cnn_err;
    ix1 = layer_idx;
    for (int k = 0; k < 300; k++) begin
      if (cnn_finish || cnn_state == 8'd9) begin
        ended = 1'b1;
        break;
      end
      picture_finish    = (cnn_state == 8'd4);
      mp_picture_finish = (cnn_state == 8'd6);
      step();
    end
    picture_finish    = 1'b0;
    mp_picture_finish = 1'b0;
    chk("run_terminates", 32'(ended), 1);
    if (cnn_finish) step();
  endtask

  initial begin
    for (int i = 0; i < 16; i++) rom[i] = '0;

    // Reset state
    #12;
    chk("rst_outputs_or", 32'(|{desc_idx, di, dout, dr, dc, dkr, dkc, relu, mpn, dr_out,
                               dc_out, start, mp_enable, buf_sel, layer_idx, cnn_state,
                               cnn_finish, cnn_err}), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step();
    chk("idle_state", 32'(cnn_state), 0);

    // One layer, exact timing
    rom[0] = '{di: 8'd3, dout: 8'd8, dr: 8'd32, dc: 8'd32, dkr: 4'd3, dkc: 4'd3, relu: 1'b1, mp: 1'b0};
    clr();
    cnn_start = 1'b1; num_layers = 4'd1;
    step(); cnn_start = 1'b0;
    chk("t1_fetch", 32'(cnn_state), 1);
    chk("t1_desc_idx", 32'(desc_idx), 0);
    step();
    chk("t1_load", 32'(cnn_state), 2);
    chk("t1_start_early", 32'(start), 0);
    step();
    chk("t1_start", 32'(start), 1);
    chk("t1_dr_out", 32'(dr_out), 30);
    chk("t1_dc_out", 32'(dc_out), 30);
    chk("t1_cfg", 32'({di, dout, dkr, dkc}), 32'({8'd3, 8'd8, 4'd3, 4'd3}));
    chk("t1_relu", 32'(relu), 1);
    step();
    chk("t1_wait", 32'(cnn_state), 4);
    chk("t1_start_once", 32'(start), 0);
    step(); step();
    chk("t1_wait_hold", 32'(cnn_state), 4);
    picture_finish = 1'b1;
    step(); picture_finish = 1'b0;
    chk("t1_next", 32'(cnn_state), 7);
    chk("t1_fin_early", 32'(cnn_finish), 0);
    step();
    chk("t1_finish", 32'(cnn_finish), 1);
    chk("t1_buf_sel", 32'(buf_sel), 1);
    step();
    chk("t1_idle", 32'(cnn_state), 0);
    chk("t1_fin_once", 32'(cnn_finish), 0);
    chk("t1_cfg_hold", 32'(dr_out), 30);
    chk("t1_n_start", n_start, 1);

    // Two layers with pooling after layer 0
    rom[0] = '{di: 8'd3, dout: 8'd8,  dr: 8'd32, dc: 8'd32, dkr: 4'd3, dkc: 4'd3, relu: 1'b0, mp: 1'b1};
    rom[1] = '{di: 8'd8, dout: 8'd16, dr: 8'd15, dc: 8'd15, dkr: 4'd3, dkc: 4'd3, relu: 1'b0, mp: 1'b0};
    clr();
    run(4'd2, s1, e1, i1);
    chk("t2_n_start", n_start, 2);
    chk("t2_n_mp", n_mp, 1);
    chk("t2_n_fin", n_fin, 1);
    chk("t2_buf_sel", 32'(buf_sel), 0);
    chk("t2_dr_out", 32'(dr_out), 13);
    chk("t2_do", 32'(dout), 16);
    chk("t2_layer_idx", 32'(layer_idx), 1);
    chk("t2_err", 32'(cnn_err), 0);

    // Chaining error, then restart from ERR
    rom[1].di = 8'd4;
    clr();
    run(4'd2, s1, e1, i1);
    chk("t3_state", 32'(cnn_state), 9);
    chk("t3_err", 32'(cnn_err), 1);
    chk("t3_n_start", n_start, 1);
    picture_finish = 1'b1;
    step(); step(); step();
    picture_finish = 1'b0;
    chk("t3_err_hold", 32'(cnn_state), 9);
    chk("t3_no_start", n_start, 1);
    rom[1].di = 8'd8;
    clr();
    run(4'd2, s1, e1, i1);
    chk("t3_restart_state", 32'(s1), 1);
    chk("t3_restart_err", 32'(e1), 0);
    chk("t3_restart_idx", 32'(i1), 0);
    chk("t3_restart_fin", n_fin, 1);

    // Odd-sized output with pooling
    rom[0] = '{di: 8'd3, dout: 8'd8, dr: 8'd32, dc: 8'd32, dkr: 4'd2, dkc: 4'd3, relu: 1'b0, mp: 1'b1};
    clr();
    run(4'd1, s1, e1, i1);
    chk("t4_state", 32'(cnn_state), 9);
    chk("t4_no_start", n_start, 0);
    chk("t4_dr_out", 32'(dr_out), 31);

    // Zero layers, started from ERR
    clr();
    cnn_start = 1'b1; num_layers = 4'd0;
    step(); cnn_start = 1'b0;
    chk("t5_done", 32'(cnn_state), 8);
    chk("t5_finish", 32'(cnn_finish), 1);
    chk("t5_err_clr", 32'(cnn_err), 0);
    step();
    chk("t5_idle", 32'(cnn_state), 0);
    chk("t5_no_start", n_start, 0);
    picture_finish = 1'b1;
    step(); picture_finish = 1'b0;
    chk("t5_stray_pf", 32'(cnn_state), 0);

    // cnn_start ignored in CONV_WAIT
    rom[0] = '{di: 8'd3, dout: 8'd8, dr: 8'd32, dc: 8'd32, dkr: 4'd3, dkc: 4'd3, relu: 1'b0, mp: 1'b0};
    cnn_start = 1'b1; num_layers = 4'd1;
    step(); cnn_start = 1'b0;
    step(); step(); step();
    chk("t6_wait", 32'(cnn_state), 4);
    cnn_start = 1'b1; num_layers = 4'd0;
    step(); cnn_start = 1'b0;
    chk("t6_ignored", 32'(cnn_state), 4);
    mp_picture_finish = 1'b1;
    step(); mp_picture_finish = 1'b0;
    chk("t6_stray_mpf", 32'(cnn_state), 4);

    // Reset during CONV_WAIT
    #2 rst_n = 1'b0;
    #1;
    chk("t7_state", 32'(cnn_state), 0);
    chk("t7_outputs_or", 32'(|{desc_idx, di, dout, dr, dc, dkr, dkc, relu, mpn, dr_out,
                              dc_out, start, mp_enable, buf_sel, layer_idx, cnn_finish,
                              cnn_err}), 0);
    clr();
    picture_finish = 1'b1;
    step(); step();
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) step();
    picture_finish = 1'b0;
    chk("t7_no_pulses", n_start + n_fin + n_mp, 0);
    chk("t7_idle", 32'(cnn_state), 0);

    // Remaining descriptor checks
    rom[0] = '{di: 8'd3, dout: 8'd8, dr: 8'd32, dc: 8'd32, dkr: 4'd0, dkc: 4'd3, relu: 1'b0, mp: 1'b0};
    run(4'd1, s1, e1, i1);
    chk("t8_dkr_zero", 32'(cnn_state), 9);
    rom[0] = '{di: 8'd3, dout: 8'd8, dr: 8'd32, dc: 8'd2, dkr: 4'd3, dkc: 4'd3, relu: 1'b0, mp: 1'b0};
    run(4'd1, s1, e1, i1);
    chk("t8_dkc_gt_dc", 32'(cnn_state), 9);
    rom[0] = '{di: 8'd3, dout: 8'd8, dr: 8'd32, dc: 8'd32, dkr: 4'd3, dkc: 4'd3, relu: 1'b0, mp: 1'b0};
    clr();
    run(4'd9, s1, e1, i1);
    chk("t8_num_gt_max", 32'(cnn_state), 9);
    chk("t8_num_no_start", n_start, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
